slave_out: RTL and testbench

SLAVE_OUT -- requirements
Module: slave_out

---
 rtl/bus_pkg.sv | 19 +
 rtl/slave_out_piso.sv | 36 +++
 rtl/slave_out.sv | 109 ++++++++++
 tb/tb_slave_out.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the serial read path.
// Holds the read opcode, slave FSM encoding and default widths.
package bus_pkg;

    localparam logic [1:0] INSTR_READ = 2'b11;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_BURST_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RDY,
        SHIFT,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/slave_out_piso.sv
// Parallel-in serial-out shifter, LSB first.
// Tracks the bit position and flags the final bit of a byte.
module piso_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              shift,
    output logic              dout,
    output logic              last
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;

    assign dout = sr[0];
    assign last = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= din;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr >> 1;
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/slave_out.sv
// Slave read-return path: fetches burst bytes from memory
// and serializes each one to the master, LSB first.
module slave_out
    import bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_done,
    input  logic [1:0]         instruction,
    input  logic [BURST_W-1:0] burst_num,
    input  logic               master_ready,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               mem_valid,
    output logic               mem_req,
    output logic [BURST_W-1:0] mem_offset,
    output logic               slave_valid,
    output logic               rx_data,
    output logic               slave_done,
    output logic               busy
);

    state_t state;
    state_t next;

    logic [BURST_W-1:0] idx;
    logic [BURST_W-1:0] total;
    logic [BURST_W:0]   idx_nxt;
    logic               more;
    logic               req_sent;
    logic               load;
    logic               shift;
    logic               last;
    logic               bit_out;

    // one extra bit so a full-scale burst never wraps the compare
    assign idx_nxt = {1'b0, idx} + {{BURST_W{1'b0}}, 1'b1};
    assign more    = idx_nxt < {1'b0, total};

    always_comb begin
        next  = state;
        load  = 1'b0;
        shift = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_done && instruction == INSTR_READ)
                    next = FETCH;
            end
            FETCH: begin
                if (mem_valid) begin
                    load = 1'b1;
                    next = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (master_ready)
                    next = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                if (last)
                    next = more ? GAP : DONE;
            end
            GAP:     next = FETCH;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            total    <= '0;
            req_sent <= 1'b0;
        end else begin
            state    <= next;
            req_sent <= (state == FETCH) && (next == FETCH);
            if (state == IDLE && next == FETCH) begin
                idx   <= '0;
                total <= (burst_num == '0) ? BURST_W'(1) : burst_num;
            end
            if (state == SHIFT && last && more)
                idx <= idx_nxt[BURST_W-1:0];
        end
    end

    piso_shifter #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (mem_data),
        .shift (shift),
        .dout  (bit_out),
        .last  (last)
    );

    assign mem_req     = (state == FETCH) && !req_sent;
    assign mem_offset  = idx;
    assign slave_valid = (state == SHIFT);
    assign rx_data     = slave_valid & bit_out;
    assign slave_done  = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_slave_out.sv
// Directed bench for slave_out: single, burst, backpressure,
// reset, non-read, latency and full-scale burst cases.
module tb_slave_out;

    localparam int DW = 8;
    localparam int BW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_done;
    logic [1:0]    instruction;
    logic [BW-1:0] burst_num;
    logic          master_ready;
    logic [DW-1:0] mem_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_req;
    logic [BW-1:0] mem_offset;
    logic          slave_valid;
    logic          rx_data;
    logic          slave_done;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    slave_out #(
        .DATA_W  (DW),
        .BURST_W (BW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_done      (tx_done),
        .instruction  (instruction),
        .burst_num    (burst_num),
        .master_ready (master_ready),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .mem_req      (mem_req),
        .mem_offset   (mem_offset),
        .slave_valid  (slave_valid),
        .rx_data      (rx_data),
        .slave_done   (slave_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // memory responder with configurable latency
    logic [7:0]    tbl [0:4095];
    int            lat_cfg = 0;
    int            pend = 0;
    logic [BW-1:0] off_lat = '0;
    int            req_cnt = 0;
    int            req_offs [$];

    always begin
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_valid = 1'b1;
                mem_data  = tbl[off_lat];
            end
        end
        if (mem_req === 1'b1) begin
            req_cnt++;
            req_offs.push_back(int'(mem_offset));
            off_lat = mem_offset;
            if (lat_cfg == 0) begin
                mem_valid = 1'b1;
                mem_data  = tbl[mem_offset];
            end else begin
                pend = lat_cfg;
            end
        end
    end

    // serial receiver, sampled on the falling edge
    int         nb = 0;
    logic [7:0] cur = '0;
    logic [7:0] rx_bytes [$];
    int         done_cnt = 0;
    int         partial_cnt = 0;
    int         b2b = 0;
    int         prev_full = 0;
    int         valid_cyc = 0;
    int         idle_bad = 0;

    always @(negedge clk) begin
        if (slave_valid === 1'b1) begin
            if (prev_full != 0) b2b++;
            prev_full = 0;
            valid_cyc++;
            cur = {rx_data, cur[7:1]};
            nb++;
            if (nb == 8) begin
                rx_bytes.push_back(cur);
                nb = 0;
                prev_full = 1;
            end
        end else begin
            if (nb != 0) partial_cnt++;
            nb = 0;
            prev_full = 0;
            if (rx_data !== 1'b0) idle_bad++;
        end
        if (slave_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] byte_at(input int i);
        if (i < rx_bytes.size()) return 32'(rx_bytes[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] off_at(input int i);
        if (i < req_offs.size()) return 32'(req_offs[i]);
        return 32'hDEAD;
    endfunction

    task automatic clear();
        req_cnt = 0;
        req_offs.delete();
        rx_bytes.delete();
        done_cnt = 0;
        partial_cnt = 0;
        b2b = 0;
        valid_cyc = 0;
        idle_bad = 0;
    endtask

    // pulse tx_done, then disturb the request fields
    task automatic start(input logic [1:0] ins,
                         input logic [BW-1:0] bn);
        instruction = ins;
        burst_num = bn;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        instruction = 2'b00;
        burst_num = 12'hABC;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b1;
        tx_done = 1'b0;
        instruction = 2'b00;
        burst_num = '0;
        master_ready = 1'b1;
        tick(2);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_offset", 32'(mem_offset), 0);
        chk("rst_valid", 32'(slave_valid), 0);
        chk("rst_rx", 32'(rx_data), 0);
        chk("rst_done", 32'(slave_done), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();
        clear();

        // single read of D6
        tbl[0] = 8'hD6;
        start(2'b11, 12'd0);
        chk("s_req", 32'(mem_req), 1);
        chk("s_off", 32'(mem_offset), 0);
        chk("s_busy", 32'(busy), 1);
        tick();
        chk("s_req_once", 32'(mem_req), 0);
        chk("s_wait_valid", 32'(slave_valid), 0);
        tick();
        chk("s_shift_valid", 32'(slave_valid), 1);
        chk("s_bit0", 32'(rx_data), 0);
        wait_idle("s_timeout", 100);
        chk("s_nbytes", 32'(rx_bytes.size()), 1);
        chk("s_byte", byte_at(0), 32'hD6);
        chk("s_done_cnt", 32'(done_cnt), 1);
        chk("s_req_cnt", 32'(req_cnt), 1);
        chk("s_valid_cyc", 32'(valid_cyc), 8);
        chk("s_idle_rx", 32'(idle_bad), 0);
        clear();

        // three-byte burst
        tbl[0] = 8'h5E;
        tbl[1] = 8'hD4;
        tbl[2] = 8'hDE;
        start(2'b11, 12'd3);
        wait_idle("b_timeout", 200);
        chk("b_nbytes", 32'(rx_bytes.size()), 3);
        chk("b_byte0", byte_at(0), 32'h5E);
        chk("b_byte1", byte_at(1), 32'hD4);
        chk("b_byte2", byte_at(2), 32'hDE);
        chk("b_req_cnt", 32'(req_cnt), 3);
        chk("b_off0", off_at(0), 0);
        chk("b_off1", off_at(1), 1);
        chk("b_off2", off_at(2), 2);
        chk("b_done_cnt", 32'(done_cnt), 1);
        chk("b_gap", 32'(b2b), 0);
        chk("b_valid_cyc", 32'(valid_cyc), 24);
        chk("b_idle_rx", 32'(idle_bad), 0);
        clear();

        // backpressure before and during the byte
        tbl[0] = 8'hA5;
        master_ready = 1'b0;
        start(2'b11, 12'd0);
        chk("bp_req", 32'(mem_req), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", 32'(slave_valid), 0);
        end
        chk("bp_busy", 32'(busy), 1);
        master_ready = 1'b1;
        tick();
        chk("bp_start", 32'(slave_valid), 1);
        chk("bp_bit0", 32'(rx_data), 1);
        tick(2);
        master_ready = 1'b0;
        wait_idle("bp_timeout", 100);
        chk("bp_byte", byte_at(0), 32'hA5);
        chk("bp_valid_cyc", 32'(valid_cyc), 8);
        chk("bp_partial", 32'(partial_cnt), 0);
        master_ready = 1'b1;
        clear();

        // reset during bit 4 of byte 2
        tbl[0] = 8'h11;
        tbl[1] = 8'h22;
        tbl[2] = 8'h33;
        start(2'b11, 12'd3);
        n = 0;
        while (!(rx_bytes.size() == 1 && nb == 4 &&
                 slave_valid === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("r_reach_bit4", 32'(n < 200), 1);
        reset = 1'b1;
        tx_done = 1'b1;
        instruction = 2'b11;
        tick();
        chk("r_mem_req", 32'(mem_req), 0);
        chk("r_mem_offset", 32'(mem_offset), 0);
        chk("r_valid", 32'(slave_valid), 0);
        chk("r_rx", 32'(rx_data), 0);
        chk("r_done", 32'(slave_done), 0);
        chk("r_busy", 32'(busy), 0);
        reset = 1'b0;
        tx_done = 1'b0;
        tick();
        chk("r_busy_after", 32'(busy), 0);
        chk("r_partial", 32'(partial_cnt), 1);
        chk("r_done_cnt", 32'(done_cnt), 0);
        clear();
        start(2'b11, 12'd2);
        wait_idle("r_timeout", 200);
        chk("r_off0", off_at(0), 0);
        chk("r_off1", off_at(1), 1);
        chk("r_byte0", byte_at(0), 32'h11);
        chk("r_byte1", byte_at(1), 32'h22);
        chk("r_done_cnt2", 32'(done_cnt), 1);
        clear();

        // non-read instruction is ignored
        start(2'b01, 12'd5);
        tick(3);
        chk("n_busy", 32'(busy), 0);
        chk("n_req_cnt", 32'(req_cnt), 0);

        // tx_done while shifting is ignored
        tbl[0] = 8'h3C;
        start(2'b11, 12'd0);
        n = 0;
        while (slave_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("n_reach_shift", 32'(slave_valid), 1);
        start(2'b11, 12'd5);
        wait_idle("n_timeout", 100);
        chk("n_req_once", 32'(req_cnt), 1);
        chk("n_nbytes", 32'(rx_bytes.size()), 1);
        chk("n_byte", byte_at(0), 32'h3C);
        chk("n_done_cnt", 32'(done_cnt), 1);
        clear();

        // three-cycle memory latency
        lat_cfg = 3;
        tbl[0] = 8'h9A;
        start(2'b11, 12'd0);
        chk("l_req", 32'(mem_req), 1);
        tick();
        chk("l_req_drop", 32'(mem_req), 0);
        chk("l_busy", 32'(busy), 1);
        wait_idle("l_timeout", 100);
        chk("l_req_cnt", 32'(req_cnt), 1);
        chk("l_byte", byte_at(0), 32'h9A);
        chk("l_done_cnt", 32'(done_cnt), 1);
        lat_cfg = 0;
        clear();

        // full-scale burst, no counter wrap
        for (int i = 0; i < 4096; i++)
            tbl[i] = 8'(i) ^ 8'h5A;
        start(2'b11, 12'hFFF);
        wait_idle("m_timeout", 50000);
        chk("m_req_cnt", 32'(req_cnt), 4095);
        chk("m_off_last", off_at(4094), 4094);
        chk("m_nbytes", 32'(rx_bytes.size()), 4095);
        bad = 0;
        for (int i = 0; i < rx_bytes.size(); i++)
            if (rx_bytes[i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("m_data_errs", 32'(bad), 0);
        chk("m_done_cnt", 32'(done_cnt), 1);
        chk("m_gap", 32'(b2b), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
